// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the owner encoding used in response tags, the tag layout that
// travels alongside each read through the memory latency, and the default
// latency / starvation-limit values used by the arbiter and its sub-module.
package mem_port_arbiter_pkg;

  // Which requester a read response belongs to.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // One entry of the response tag pipeline.
  typedef struct packed {
    logic valid;
    logic owner;
  } resp_tag_t;

  localparam int TAG_W = $bits(resp_tag_t);

  // Defaults: one-cycle synchronous memory, four back-to-back D grants
  // before a waiting fetch is forced through.
  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

  // Build a tag from its fields.
  function automatic resp_tag_t make_tag(input logic valid, input logic owner);
    resp_tag_t t;
    t.valid = valid;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// resp_tag_pipe: DEPTH-deep shift register of response tags.
// A tag is pushed every cycle (invalid when no read was granted) and
// appears at the tail exactly DEPTH cycles later, lining up with the
// memory's read data.
// Ports:
//   clk, rst            clock, synchronous active-high clear
//   push_valid/owner    tag entering the pipe this cycle
//   tail_valid/owner    tag leaving the pipe this cycle
module resp_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_owner,
  output logic tail_valid,
  output logic tail_owner
);

  resp_tag_t stage_q [DEPTH];
  resp_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = make_tag(push_valid, push_owner);
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Reset discards every in-flight tag so no stale rvalid can follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tail_valid = stage_q[DEPTH-1].valid;
  assign tail_owner = stage_q[DEPTH-1].owner;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction
// fetch (I) and load/store (D). One grant per cycle, D has priority
// except when a waiting fetch has been passed over STARVE_MAX times in a
// row. Read responses are routed back to their owner via a tag pipeline
// matched to the memory latency.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_req/i_addr -> i_gnt           fetch request / acceptance
//   i_rvalid/i_rdata                fetch response
//   d_req/d_we/d_be/d_addr/d_wdata  load/store request, d_gnt acceptance
//   d_rvalid/d_rdata                load response
//   mem_en/we/be/addr/wdata         memory port command
//   mem_rdata                       memory read data, MEM_LAT after strobe
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 16,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             push_valid, push_owner;
  logic             tail_valid, tail_owner;

  // Grant selection. Everything is forced low while rst is high so the
  // port is quiet during reset even though grants are combinational.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (i_req && d_req) begin
        if (starve_cnt_q == STARVE_LIMIT) i_gnt = 1'b1;
        else                              d_gnt = 1'b1;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // Memory command mux; idle fields stay at zero.
  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (d_gnt) begin
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_be   = 4'hF;
      mem_addr = i_addr;
    end
  end

  // Starvation counter: counts D grants that bypass a waiting fetch.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_gnt) begin
      starve_cnt_d = '0;
    end else if (d_gnt && starve_cnt_q != STARVE_LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end

  // Stores push an invalid tag so they never produce an rvalid.
  assign push_valid = i_gnt | (d_gnt & ~d_we);
  assign push_owner = d_gnt ? OWN_D : OWN_I;

  resp_tag_pipe #(
    .DEPTH(MEM_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .push_valid(push_valid),
    .push_owner(push_owner),
    .tail_valid(tail_valid),
    .tail_owner(tail_owner)
  );

  // The tail tag is still populated during the first reset cycle, so the
  // return path is also gated by rst.
  assign i_rvalid = ~rst & tail_valid & (tail_owner == OWN_I);
  assign d_rvalid = ~rst & tail_valid & (tail_owner == OWN_D);
  assign i_rdata  = rst ? 32'h0 : mem_rdata;
  assign d_rdata  = rst ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Instance A uses MEM_LAT=1 with a
// byte-writable memory model; instance B uses MEM_LAT=3 with a read-only
// address-pattern memory for the pipelined routing check.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst;

   // Instance A signals (MEM_LAT = 1)
   logic        iReq, iGnt, iRvalid, dReq, dWe, dGnt, dRvalid;
   logic [15:0] iAddr, dAddr, memAddr;
   logic [3:0]  dBe, memBe;
   logic [31:0] dWdata, iRdata, dRdata, memWdata, memRdata;
   logic        memEn, memWe;

   // Instance B signals (MEM_LAT = 3)
   logic        iReqB, iGntB, iRvalidB, dReqB, dGntB, dRvalidB;
   logic [15:0] iAddrB, dAddrB, memAddrB;
   logic [3:0]  memBeB;
   logic [31:0] iRdataB, dRdataB, memWdataB, memRdataB;
   logic        memEnB, memWeB;

   int vecCount = 0;
   int missCount = 0;

   mem_port_arbiter #(.AW(16), .MEM_LAT(1), .STARVE_MAX(4)) dutA (
      .clk(clk), .rst(rst),
      .i_req(iReq), .i_addr(iAddr), .i_gnt(iGnt), .i_rvalid(iRvalid), .i_rdata(iRdata),
      .d_req(dReq), .d_we(dWe), .d_be(dBe), .d_addr(dAddr), .d_wdata(dWdata),
      .d_gnt(dGnt), .d_rvalid(dRvalid), .d_rdata(dRdata),
      .mem_en(memEn), .mem_we(memWe), .mem_be(memBe), .mem_addr(memAddr),
      .mem_wdata(memWdata), .mem_rdata(memRdata)
   );

   mem_port_arbiter #(.AW(16), .MEM_LAT(3), .STARVE_MAX(4)) dutB (
      .clk(clk), .rst(rst),
      .i_req(iReqB), .i_addr(iAddrB), .i_gnt(iGntB), .i_rvalid(iRvalidB), .i_rdata(iRdataB),
      .d_req(dReqB), .d_we(1'b0), .d_be(4'h0), .d_addr(dAddrB), .d_wdata(32'h0),
      .d_gnt(dGntB), .d_rvalid(dRvalidB), .d_rdata(dRdataB),
      .mem_en(memEnB), .mem_we(memWeB), .mem_be(memBeB), .mem_addr(memAddrB),
      .mem_wdata(memWdataB), .mem_rdata(memRdataB)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Memory A: 1024 words preloaded with A500_0000 | index on the first
   // edge, byte-enabled writes, one-cycle registered read.
   logic [31:0] memA [0:1023];
   logic        memInitDone = 1'b0;
   always @(posedge clk) begin
      if (!memInitDone) begin
         for (int k = 0; k < 1024; k++) memA[k] <= 32'hA500_0000 | 32'(k);
         memInitDone <= 1'b1;
      end else if (memEn) begin
         if (memWe) begin
            for (int b = 0; b < 4; b++)
               if (memBe[b]) memA[memAddr[9:0]][8*b +: 8] <= memWdata[8*b +: 8];
         end else begin
            memRdata <= memA[memAddr[9:0]];
         end
      end
   end

   // Memory B: data is B000_0000 | address, delivered three cycles later.
   logic [31:0] pipeB0, pipeB1, pipeB2;
   always @(posedge clk) begin
      pipeB0 <= 32'hB000_0000 | 32'(memAddrB);
      pipeB1 <= pipeB0;
      pipeB2 <= pipeB1;
   end
   assign memRdataB = pipeB2;

   // Drive instance A for one cycle (instance B idle), then settle.
   task automatic applyStimulus(input logic rstV, input logic iReqV, input logic [15:0] iAddrV,
                                input logic dReqV, input logic dWeV, input logic [3:0] dBeV,
                                input logic [15:0] dAddrV, input logic [31:0] dWdataV);
      @(negedge clk);
      rst = rstV;
      iReq = iReqV; iAddr = iAddrV;
      dReq = dReqV; dWe = dWeV; dBe = dBeV; dAddr = dAddrV; dWdata = dWdataV;
      iReqB = 1'b0; iAddrB = 16'h0; dReqB = 1'b0; dAddrB = 16'h0;
      #1;
   endtask

   // Drive instance B for one cycle (instance A idle), then settle.
   task automatic applyStimulusB(input logic iReqV, input logic [15:0] iAddrV,
                                 input logic dReqV, input logic [15:0] dAddrV);
      @(negedge clk);
      rst = 1'b0;
      iReq = 1'b0; iAddr = 16'h0; dReq = 1'b0; dWe = 1'b0; dBe = 4'h0; dAddr = 16'h0; dWdata = 32'h0;
      iReqB = iReqV; iAddrB = iAddrV; dReqB = dReqV; dAddrB = dAddrV;
      #1;
   endtask

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      assert (observed === expected)
      else begin
         missCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Directed test sequence.
   initial begin
      rst = 1'b1;
      iReq = 1'b0; iAddr = 16'h0; dReq = 1'b0; dWe = 1'b0; dBe = 4'h0; dAddr = 16'h0; dWdata = 32'h0;
      iReqB = 1'b0; iAddrB = 16'h0; dReqB = 1'b0; dAddrB = 16'h0;

      // Reset with both requests active: port must stay silent.
      applyStimulus(1, 1, 16'h0, 1, 0, 4'h0, 16'h100, 32'h0);
      checkOutput("rst_i_gnt", 32'(iGnt), 32'd0);
      checkOutput("rst_d_gnt", 32'(dGnt), 32'd0);
      checkOutput("rst_mem_en", 32'(memEn), 32'd0);
      checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
      checkOutput("rst_rvalid", 32'({iRvalid, dRvalid}), 32'd0);
      applyStimulus(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);

      // Fetch only, three consecutive words.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0, k < 3, 16'(k), 0, 0, 4'h0, 16'h0, 32'h0);
         checkOutput("fetch_i_gnt", 32'(iGnt), (k < 3) ? 32'd1 : 32'd0);
         if (k < 3) begin
            checkOutput("fetch_mem_addr", 32'(memAddr), 32'(k));
            checkOutput("fetch_mem_be", 32'(memBe), 32'hF);
         end
         checkOutput("fetch_i_rvalid", 32'(iRvalid), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
         if (k >= 1 && k <= 3) checkOutput("fetch_i_rdata", iRdata, 32'hA500_0000 | 32'(k - 1));
         checkOutput("fetch_d_rvalid", 32'(dRvalid), 32'd0);
      end

      // Conflict: D wins, then the held fetch is granted.
      applyStimulus(0, 1, 16'h5, 1, 0, 4'h0, 16'h100, 32'h0);
      checkOutput("conf_d_gnt", 32'(dGnt), 32'd1);
      checkOutput("conf_i_gnt", 32'(iGnt), 32'd0);
      checkOutput("conf_mem_addr", 32'(memAddr), 32'h100);
      applyStimulus(0, 1, 16'h5, 0, 0, 4'h0, 16'h0, 32'h0);
      checkOutput("conf_i_gnt2", 32'(iGnt), 32'd1);
      checkOutput("conf_d_rvalid", 32'(dRvalid), 32'd1);
      checkOutput("conf_d_rdata", dRdata, 32'hA500_0100);
      checkOutput("conf_i_rvalid0", 32'(iRvalid), 32'd0);
      applyStimulus(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      checkOutput("conf_i_rvalid", 32'(iRvalid), 32'd1);
      checkOutput("conf_i_rdata", iRdata, 32'hA500_0005);

      // Starvation: four D grants, forced I grant, four more D grants
      // (counter restarted), then the re-issued fetch goes through.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1, 16'h20, 1, 0, 4'h0, 16'(16'h30 + k), 32'h0);
         checkOutput("starve_d_gnt", 32'({iGnt, dGnt}), 32'b01);
         checkOutput("starve_mem_addr", 32'(memAddr), 32'(16'h30 + k));
         if (k > 0) checkOutput("starve_d_rdata", dRdata, 32'hA500_0030 | 32'(k - 1));
      end
      applyStimulus(0, 1, 16'h20, 1, 0, 4'h0, 16'h34, 32'h0);
      checkOutput("starve_i_forced", 32'({iGnt, dGnt}), 32'b10);
      checkOutput("starve_i_addr", 32'(memAddr), 32'h20);
      checkOutput("starve_last_d", dRdata, 32'hA500_0033);
      for (int k = 4; k < 8; k++) begin
         applyStimulus(0, 1, 16'h21, 1, 0, 4'h0, 16'(16'h30 + k), 32'h0);
         checkOutput("starve_d_resume", 32'({iGnt, dGnt}), 32'b01);
         if (k == 4) checkOutput("starve_i_rdata", 32'({iRvalid, dRvalid}), 32'b10);
      end
      applyStimulus(0, 1, 16'h21, 0, 0, 4'h0, 16'h0, 32'h0);
      checkOutput("starve_i_single", 32'({iGnt, dGnt}), 32'b10);
      checkOutput("starve_d_rdata7", dRdata, 32'hA500_0037);
      applyStimulus(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      checkOutput("starve_i_rdata21", iRdata, 32'hA500_0021);

      // Partial store followed by a load of the same word.
      applyStimulus(0, 0, 16'h0, 1, 1, 4'b0011, 16'h10, 32'hDEAD_BEEF);
      checkOutput("st_d_gnt", 32'(dGnt), 32'd1);
      checkOutput("st_mem_we", 32'(memWe), 32'd1);
      checkOutput("st_mem_be", 32'(memBe), 32'h3);
      checkOutput("st_mem_wdata", memWdata, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 16'h0, 1, 0, 4'h0, 16'h10, 32'h0);
      checkOutput("ld_mem_we", 32'(memWe), 32'd0);
      checkOutput("st_no_rvalid", 32'(dRvalid), 32'd0);
      applyStimulus(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      checkOutput("ld_d_rvalid", 32'(dRvalid), 32'd1);
      checkOutput("ld_d_rdata", dRdata, 32'hA500_BEEF);

      // MEM_LAT=3: alternating I/D loads, responses in cycles 3..6.
      for (int k = 0; k < 8; k++) begin
         applyStimulusB(k < 4 && k % 2 == 0, 16'(16'h40 + k), k < 4 && k % 2 == 1, 16'(16'h40 + k));
         if (k < 4) checkOutput("lat3_gnt", 32'({iGntB, dGntB}), (k % 2 == 0) ? 32'b10 : 32'b01);
         checkOutput("lat3_i_rvalid", 32'(iRvalidB), (k == 3 || k == 5) ? 32'd1 : 32'd0);
         checkOutput("lat3_d_rvalid", 32'(dRvalidB), (k == 4 || k == 6) ? 32'd1 : 32'd0);
         if (k == 3 || k == 5) checkOutput("lat3_i_rdata", iRdataB, 32'hB000_0040 | 32'(k - 3));
         if (k == 4 || k == 6) checkOutput("lat3_d_rdata", dRdataB, 32'hB000_0040 | 32'(k - 3));
      end

      // Reset while a load is in flight.
      applyStimulus(0, 0, 16'h0, 1, 0, 4'h0, 16'h100, 32'h0);
      checkOutput("rmid_d_gnt", 32'(dGnt), 32'd1);
      applyStimulus(1, 1, 16'h7, 1, 0, 4'h0, 16'h101, 32'h0);
      checkOutput("rmid_gnts", 32'({iGnt, dGnt, memEn}), 32'd0);
      checkOutput("rmid_rvalid", 32'({iRvalid, dRvalid}), 32'd0);
      checkOutput("rmid_d_rdata", dRdata, 32'h0);
      applyStimulus(0, 0, 16'h0, 1, 0, 4'h0, 16'h101, 32'h0);
      checkOutput("rmid_resume_gnt", 32'(dGnt), 32'd1);
      checkOutput("rmid_no_stale", 32'(dRvalid), 32'd0);
      applyStimulus(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      checkOutput("rmid_new_rvalid", 32'(dRvalid), 32'd1);
      checkOutput("rmid_new_rdata", dRdata, 32'hA500_0101);
      applyStimulus(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      checkOutput("rmid_quiet", 32'({iRvalid, dRvalid}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
